// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, instruction field ranges and the
// fetch-stage state encoding.
package mips_pkg;

   localparam logic [5:0] OP_R_FORMAT = 6'd0;
   localparam logic [5:0] OP_J        = 6'd2;
   localparam logic [5:0] OP_BEQ      = 6'd4;
   localparam logic [5:0] OP_LW       = 6'd35;
   localparam logic [5:0] OP_SW       = 6'd43;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 26;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;
   localparam int TGT_HI = 25;
   localparam int TGT_LO = 0;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_ERR   = 2'd2
   } fetch_state_t;

   // Sign-extended, word-scaled BEQ displacement.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_next_pc.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
// Also flags a target whose low two bits are non-zero.
module ifetch_next_pc
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] ir,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   logic [31:0] pc4;

   always_comb begin
      pc4 = pc + 32'd4;
      if (jump) begin
         next_pc = {pc4[31:28], ir[TGT_HI:TGT_LO], 2'b00};
      end else if (branch && zero) begin
         next_pc = pc4 + branch_offset(ir[IMM_HI:IMM_LO]);
      end else begin
         next_pc = pc4;
      end
      misaligned = |next_pc[1:0];
   end

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch stage: PC, instruction register, ack timeout
// and valid/ready hand-off to decode. Optional macro IFETCH_ALIGN_CHK_EN.
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          ACK_TIMEOUT = 255,
   parameter int          TIMEOUT_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [5:0]  id_opcode,
   output logic [31:0] id_pc4,
   input  logic        ex_branch,
   input  logic        ex_zero,
   input  logic        ex_jump,
   output logic        fetch_err
);

   fetch_state_t         state_reg, state_next;
   logic [31:0]          pc_reg, pc_next;
   logic [31:0]          ir_reg, ir_next;
   logic [TIMEOUT_W-1:0] cnt_reg, cnt_next;
   // Keeps the request low until the first edge after reset is released.
   logic                 armed_reg;

   logic [31:0] target_pc;
   logic        target_misaligned;

   ifetch_next_pc u_next_pc (
      .pc         (pc_reg),
      .ir         (ir_reg),
      .branch     (ex_branch),
      .zero       (ex_zero),
      .jump       (ex_jump),
      .next_pc    (target_pc),
      .misaligned (target_misaligned)
   );

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      ir_next    = ir_reg;
      cnt_next   = cnt_reg;
      imem_req   = 1'b0;
      id_valid   = 1'b0;
      fetch_err  = 1'b0;
      case (state_reg)
         S_FETCH: begin
            if (armed_reg) begin
               imem_req = 1'b1;
               if (imem_ack) begin
                  ir_next    = imem_rdata;
                  cnt_next   = '0;
                  state_next = S_HOLD;
               end else if (cnt_reg == TIMEOUT_W'(ACK_TIMEOUT)) begin
                  state_next = S_ERR;
               end else begin
                  cnt_next = cnt_reg + TIMEOUT_W'(1);
               end
            end
         end
         S_HOLD: begin
            id_valid = 1'b1;
            if (id_ready) begin
`ifdef IFETCH_ALIGN_CHK_EN
               if (target_misaligned) begin
                  state_next = S_ERR;
               end else begin
                  pc_next    = target_pc;
                  state_next = S_FETCH;
               end
`else
               pc_next    = target_misaligned ? {target_pc[31:2], 2'b00} : target_pc;
               state_next = S_FETCH;
`endif
            end
         end
         S_ERR: begin
            fetch_err = 1'b1;
         end
         default: begin
            state_next = S_ERR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_FETCH;
         pc_reg    <= RESET_PC;
         ir_reg    <= '0;
         cnt_reg   <= '0;
         armed_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         ir_reg    <= ir_next;
         cnt_reg   <= cnt_next;
         armed_reg <= 1'b1;
      end
   end

   assign imem_addr = pc_reg;
   assign id_instr  = ir_reg;
   assign id_opcode = ir_reg[OP_HI:OP_LO];
   assign id_pc4    = pc_reg + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, sequential/branch/jump PC update,
// backpressure and the ack timeout boundary.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [5:0]  id_opcode;
   logic [31:0] id_pc4;
   logic        ex_branch;
   logic        ex_zero;
   logic        ex_jump;
   logic        fetch_err;

   int n_checks = 0;
   int n_errors = 0;

   instr_fetch dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .id_valid   (id_valid),
      .id_ready   (id_ready),
      .id_instr   (id_instr),
      .id_opcode  (id_opcode),
      .id_pc4     (id_pc4),
      .ex_branch  (ex_branch),
      .ex_zero    (ex_zero),
      .ex_jump    (ex_jump),
      .fetch_err  (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] word);
      $display("fetch   pc=%h word=%h", imem_addr, word);
      imem_ack   = 1'b1;
      imem_rdata = word;
      step();
      imem_ack   = 1'b0;
      imem_rdata = '0;
   endtask

   task automatic consume(input logic b, input logic z, input logic j);
      $display("consume pc=%h ir=%h branch=%0b zero=%0b jump=%0b", imem_addr, id_instr, b, z, j);
      id_ready  = 1'b1;
      ex_branch = b;
      ex_zero   = z;
      ex_jump   = j;
      step();
      id_ready  = 1'b0;
      ex_branch = 1'b0;
      ex_zero   = 1'b0;
      ex_jump   = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0;
      ex_branch = 1'b0; ex_zero = 1'b0; ex_jump = 1'b0;

      // T1: reset values, then reset asserted in the middle of a fetch wait
      step();
      check("rst_req",   32'(imem_req),  32'd0);
      check("rst_valid", 32'(id_valid),  32'd0);
      check("rst_err",   32'(fetch_err), 32'd0);
      check("rst_ir",    id_instr,       32'h0);
      rst_n = 1'b1;
      #1;
      check("rel_req_before_edge", 32'(imem_req), 32'd0);
      step();
      check("rel_req", 32'(imem_req), 32'd1);
      check("rel_addr", imem_addr, 32'h0);
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      $display("reset   asserted mid-wait");
      check("midrst_req",   32'(imem_req), 32'd0);
      check("midrst_valid", 32'(id_valid), 32'd0);
      #2 rst_n = 1'b1;
      step();
      check("midrst_addr", imem_addr, 32'h0);
      check("midrst_req2", 32'(imem_req), 32'd1);

      // T2: sequential fetch of an LW
      fetch(32'h8C08_0004);
      check("t2_valid",  32'(id_valid),  32'd1);
      check("t2_req",    32'(imem_req),  32'd0);
      check("t2_opcode", 32'(id_opcode), 32'd35);
      check("t2_instr",  id_instr,       32'h8C08_0004);
      check("t2_pc4",    id_pc4,         32'h4);
      consume(1'b0, 1'b0, 1'b0);
      check("t2_valid_drop", 32'(id_valid), 32'd0);
      check("t2_req_again",  32'(imem_req), 32'd1);
      check("t2_next_addr",  imem_addr,     32'h4);

      // T5: backpressure, with a stray ack during hold that must be ignored
      fetch(32'h0000_0020);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
         end
         step();
         imem_ack = 1'b0; imem_rdata = '0;
         $display("stall   cycle=%0d ir=%h", i, id_instr);
         check("t5_instr", id_instr,       32'h0000_0020);
         check("t5_pc4",   id_pc4,         32'h8);
         check("t5_req",   32'(imem_req),  32'd0);
         check("t5_valid", 32'(id_valid),  32'd1);
      end
      consume(1'b0, 1'b0, 1'b0);
      check("t5_next_addr", imem_addr, 32'h8);
      fetch(32'h0); consume(1'b0, 1'b0, 1'b0);
      check("seq_c", imem_addr, 32'hC);
      fetch(32'h0); consume(1'b0, 1'b0, 1'b0);
      check("seq_10", imem_addr, 32'h10);

      // T3: BEQ with offset -1 word, taken then not taken
      fetch(32'h1000_FFFF);
      check("t3_opcode", 32'(id_opcode), 32'd4);
      consume(1'b1, 1'b1, 1'b0);
      check("t3_taken", imem_addr, 32'h10);
      fetch(32'h1000_FFFF);
      consume(1'b1, 1'b0, 1'b0);
      check("t3_not_taken", imem_addr, 32'h14);

      // T4: jump to 0x0040_0000, then jump beating a taken branch
      fetch(32'h0810_0000);
      consume(1'b0, 1'b0, 1'b1);
      check("t4_jump1", imem_addr, 32'h0040_0000);
      fetch(32'h0810_0004);
      check("t4_opcode", 32'(id_opcode), 32'd2);
      consume(1'b1, 1'b1, 1'b1);
      check("t4_jump_prio", imem_addr, 32'h0040_0010);
      fetch(32'h1000_0003);
      consume(1'b1, 1'b1, 1'b0);
      check("beq_fwd", imem_addr, 32'h0040_0020);

      // T6: ack on the last allowed request cycle is accepted
      repeat (255) step();
      check("t6_wait_req", 32'(imem_req),  32'd1);
      check("t6_wait_err", 32'(fetch_err), 32'd0);
      fetch(32'h0000_0025);
      check("t6_late_valid", 32'(id_valid),  32'd1);
      check("t6_late_err",   32'(fetch_err), 32'd0);
      check("t6_late_instr", id_instr,       32'h0000_0025);
      consume(1'b0, 1'b0, 1'b0);
      check("t6_addr", imem_addr, 32'h0040_0024);

      // T6: one cycle more without ack times out
      repeat (255) step();
      check("t6_pre_err", 32'(fetch_err), 32'd0);
      step();
      $display("timeout after 256 request cycles");
      check("t6_err",       32'(fetch_err), 32'd1);
      check("t6_err_req",   32'(imem_req),  32'd0);
      check("t6_err_valid", 32'(id_valid),  32'd0);
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678; id_ready = 1'b1;
      step(); step();
      imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0;
      check("t6_sticky", 32'(fetch_err), 32'd1);
      check("t6_err_ir", id_instr, 32'h0000_0025);

      // Reset clears the error state
      rst_n = 1'b0;
      #1;
      check("err_rst", 32'(fetch_err), 32'd0);
      #2 rst_n = 1'b1;
      step();
      check("err_rst_addr", imem_addr, 32'h0);
      check("err_rst_req",  32'(imem_req), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
